// File: rtl/input_debouncer_pkg.sv
// Shared types for the input debouncer: FSM state encoding and a helper for
// the all-ones value of a saturating counter.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE,
    RISE_WAIT,
    HIGH_STABLE,
    FALL_WAIT
  } debounce_state_t;

  function automatic int unsigned all_ones(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/input_debouncer_sat_counter.sv
// Saturating up-counter: clear has priority over enable, holds at LIMIT and
// flags it so callers can detect the end of a timed window.
module sat_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             at_limit
);

  logic [WIDTH-1:0] q_q, q_d;

  assign at_limit = (q_q == WIDTH'(LIMIT));
  assign q        = q_q;

  always_comb begin
    q_d = q_q;
    if (clr)                 q_d = '0;
    else if (en && !at_limit) q_d = q_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/input_debouncer.sv
// Debounces a synchronized level into a clean level with registered press,
// release and long-press pulses plus a saturating press count.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000,
  parameter int unsigned COUNT_WIDTH       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sync_in,
  output logic                   level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   long_press_pulse,
  output logic [COUNT_WIDTH-1:0] press_count
);

  localparam int unsigned CNT_W  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);

  debounce_state_t state_q, state_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic cnt_clr, cnt_en, cnt_sat;
  logic dcnt_en, dcnt_done;
  logic pc_sat;
  logic rise_done;

  assign rise_done = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  // cnt doubles as rise debounce timer and long-press timer; it is frozen
  // while in FALL_WAIT so a bounce on release resumes the same press.
  sat_counter #(.WIDTH(CNT_W), .LIMIT(LONG_PRESS_CYCLES)) u_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .en(cnt_en),
    .q(cnt_q), .at_limit(cnt_sat)
  );

  sat_counter #(.WIDTH(DCNT_W), .LIMIT(DEBOUNCE_CYCLES - 1)) u_dcnt (
    .clk(clk), .reset(reset), .clr(!dcnt_en), .en(dcnt_en),
    .q(dcnt_q), .at_limit(dcnt_done)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH), .LIMIT(all_ones(COUNT_WIDTH))) u_press_cnt (
    .clk(clk), .reset(reset), .clr(1'b0), .en(press_d && !pc_sat),
    .q(press_count), .at_limit(pc_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOW_STABLE;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    dcnt_en = 1'b0;
    case (state_q)
      LOW_STABLE: if (sync_in) begin
        state_d = RISE_WAIT;
        cnt_en  = 1'b1;
      end
      RISE_WAIT: begin
        if (!sync_in) begin
          state_d = LOW_STABLE;
          cnt_clr = 1'b1;
        end else if (rise_done) begin
          state_d = HIGH_STABLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (sync_in) cnt_en = 1'b1;
        else begin
          state_d = FALL_WAIT;
          dcnt_en = 1'b1;
        end
      end
      FALL_WAIT: begin
        if (sync_in) state_d = HIGH_STABLE;
        else if (dcnt_done) begin
          state_d = LOW_STABLE;
          cnt_clr = 1'b1;
        end else dcnt_en = 1'b1;
      end
      default: state_d = LOW_STABLE;
    endcase
  end

  always_comb begin
    press_d   = (state_q == RISE_WAIT) && sync_in && rise_done;
    release_d = (state_q == FALL_WAIT) && !sync_in && dcnt_done;
    long_d    = (state_q == HIGH_STABLE) && sync_in && !cnt_sat &&
                (cnt_q == CNT_W'(LONG_PRESS_CYCLES - 1));
    level_d   = (state_d == HIGH_STABLE) || (state_d == FALL_WAIT);
  end

  assign level            = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;

endmodule
